// File: rtl/arm_pkg.sv
// Shared definitions for the ARM data-processing slice.
//   - ALU opcode map (OP_AND .. OP_MVN) and condition codes (COND_EQ .. COND_NV)
//   - sequencer FSM state enum
//   - is_logical()/is_test() opcode classifiers
package arm_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  // Logical ops only produce meaningful N/Z; C and V are kept from before.
  function automatic logic is_logical(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_TST) || (op == OP_TEQ) ||
           (op == OP_ORR) || (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
  endfunction

  // TST/TEQ/CMP/CMN: flags only, never a register write.
  function automatic logic is_test(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/arm_dp_sequencer_if.sv
// Decode-to-sequencer command channel (valid/ready handshake).
//   master: decode stage (drives the command, observes cmd_ready)
//   slave : sequencer    (observes the command, drives cmd_ready)
interface arm_dp_cmd_if #(
  parameter int DW = 32,
  parameter int RW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_cond;
  logic [3:0]    cmd_opcode;
  logic          cmd_s;
  logic [RW-1:0] cmd_rd;
  logic [DW-1:0] cmd_op1;
  logic [DW-1:0] cmd_op2;

  modport master (
    output cmd_valid, cmd_cond, cmd_opcode, cmd_s, cmd_rd, cmd_op1, cmd_op2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_cond, cmd_opcode, cmd_s, cmd_rd, cmd_op1, cmd_op2,
    output cmd_ready
  );
endinterface

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluator; shared with the branch unit.
//   cond : 4-bit condition field
//   nzcv : flags {N,Z,C,V}
//   pass : 1 when the condition holds (1111 never passes)
module arm_cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    // NOTE: combinational blocks assign every output on every path, so a
    // default comes first; otherwise synthesis infers a latch.
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_dp_sequencer.sv
// Sequences one ARM data-processing command at a time through an external
// combinational ALU: IDLE (accept + condition check) -> EXEC (drive ALU,
// capture result) -> WB (register write, flag update, done pulse).
// A failed condition skips EXEC.
//   clk, reset          : clock, synchronous active-high reset
//   cmd                 : command channel (slave side)
//   alu_*               : ALU opcode/operands/carry out, result/flags in
//   rf_we/waddr/wdata   : register-file write port (WB only)
//   flag_wr_en/data     : external NZCV load, overrides a WB update
//   flags_nzcv          : current flags
//   done, done_passed   : end-of-command pulse and condition outcome
module arm_dp_sequencer
  import arm_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  arm_dp_cmd_if.slave   cmd,
  output logic [3:0]    alu_opcode,
  output logic [DW-1:0] alu_in_1,
  output logic [DW-1:0] alu_in_2,
  output logic          alu_c_in,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          flag_wr_en,
  input  logic [3:0]    flag_wr_data,
  output logic [3:0]    flags_nzcv,
  output logic          done,
  output logic          done_passed
);
  seq_state_e    state_q, state_d;
  logic [3:0]    op_q;
  logic          s_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] op1_q, op2_q, y_q;
  logic [3:0]    nzcv_q;
  logic          pass_q;
  logic          cond_pass;
  logic          accept;
  logic          flag_upd;

  // Condition uses the flags register as it stands, i.e. before any
  // flag_wr_en load landing on the same edge.
  arm_cond_check u_cond (
    .cond (cmd.cmd_cond),
    .nzcv (flags_nzcv),
    .pass (cond_pass)
  );

  assign accept        = (state_q == ST_IDLE) && cmd.cmd_valid;
  assign cmd.cmd_ready = (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd.cmd_valid) state_d = cond_pass ? ST_EXEC : ST_WB;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: command/result holding registers have no reset: they are only read
  // in EXEC/WB, which are reachable only after a load, and the state reset
  // alone guarantees no write or flag update after an abort.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd.cmd_opcode;
      s_q    <= cmd.cmd_s;
      rd_q   <= cmd.cmd_rd;
      op1_q  <= cmd.cmd_op1;
      op2_q  <= cmd.cmd_op2;
      pass_q <= cond_pass;
    end
    if (state_q == ST_EXEC) begin
      y_q    <= alu_y;
      nzcv_q <= {alu_n, alu_z, alu_c, alu_v};
    end
  end

  assign flag_upd = (state_q == ST_WB) && pass_q && (s_q || is_test(op_q));

  always_ff @(posedge clk) begin
    if (reset)           flags_nzcv <= 4'b0000;
    else if (flag_wr_en) flags_nzcv <= flag_wr_data;
    else if (flag_upd) begin
      if (is_logical(op_q)) flags_nzcv <= {nzcv_q[3:2], flags_nzcv[1:0]};
      else                  flags_nzcv <= nzcv_q;
    end
  end

  always_comb begin
    alu_opcode  = '0;
    alu_in_1    = '0;
    alu_in_2    = '0;
    alu_c_in    = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    done_passed = 1'b0;
    case (state_q)
      ST_EXEC: begin
        alu_opcode = op_q;
        alu_in_1   = op1_q;
        alu_in_2   = op2_q;
        alu_c_in   = flags_nzcv[1];
      end
      ST_WB: begin
        done        = 1'b1;
        done_passed = pass_q;
        if (pass_q && !is_test(op_q)) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = y_q;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Directed bench for arm_dp_sequencer with a behavioural ARM ALU model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_arm_dp_sequencer;
  import arm_pkg::*;

  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_in_1, alu_in_2;
  logic          alu_c_in;
  logic [DW-1:0] alu_y;
  logic          alu_n, alu_z, alu_c, alu_v;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          flag_wr_en;
  logic [3:0]    flag_wr_data;
  logic [3:0]    flags_nzcv;
  logic          done, done_passed;

  int n_cmp  = 0;
  int n_fail = 0;

  arm_dp_cmd_if #(.DW(DW), .RW(RW)) cmd_if ();

  arm_dp_sequencer #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if),
    .alu_opcode   (alu_opcode),
    .alu_in_1     (alu_in_1),
    .alu_in_2     (alu_in_2),
    .alu_c_in     (alu_c_in),
    .alu_y        (alu_y),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .flag_wr_en   (flag_wr_en),
    .flag_wr_data (flag_wr_data),
    .flags_nzcv   (flags_nzcv),
    .done         (done),
    .done_passed  (done_passed)
  );

  always #5 clk = ~clk;

  // ALU model. Logical ops report C=V=0 so that flag retention in the
  // sequencer is observable.
  logic [31:0] ax, ay, lres;
  logic        aci, arith;
  logic [32:0] asum;
  always_comb begin
    ax = '0; ay = '0; aci = 1'b0; arith = 1'b1; lres = '0;
    case (alu_opcode)
      OP_SUB, OP_CMP: begin ax = alu_in_1; ay = ~alu_in_2; aci = 1'b1; end
      OP_RSB:         begin ax = alu_in_2; ay = ~alu_in_1; aci = 1'b1; end
      OP_ADD, OP_CMN: begin ax = alu_in_1; ay = alu_in_2;  aci = 1'b0; end
      OP_ADC:         begin ax = alu_in_1; ay = alu_in_2;  aci = alu_c_in; end
      OP_SBC:         begin ax = alu_in_1; ay = ~alu_in_2; aci = alu_c_in; end
      OP_RSC:         begin ax = alu_in_2; ay = ~alu_in_1; aci = alu_c_in; end
      default:        arith = 1'b0;
    endcase
    case (alu_opcode)
      OP_AND, OP_TST: lres = alu_in_1 & alu_in_2;
      OP_EOR, OP_TEQ: lres = alu_in_1 ^ alu_in_2;
      OP_ORR:         lres = alu_in_1 | alu_in_2;
      OP_MOV:         lres = alu_in_2;
      OP_BIC:         lres = alu_in_1 & ~alu_in_2;
      OP_MVN:         lres = ~alu_in_2;
      default:        lres = '0;
    endcase
    asum  = {1'b0, ax} + {1'b0, ay} + {32'd0, aci};
    alu_y = arith ? asum[31:0] : lres;
    alu_n = alu_y[31];
    alu_z = (alu_y == '0);
    alu_c = arith & asum[32];
    alu_v = arith & (ax[31] == ay[31]) & (asum[31] != ax[31]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cond, input logic [3:0] opc, input logic s,
                      input logic [3:0] rd, input logic [31:0] op1, input logic [31:0] op2);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_cond   = cond;
    cmd_if.cmd_opcode = opc;
    cmd_if.cmd_s      = s;
    cmd_if.cmd_rd     = rd;
    cmd_if.cmd_op1    = op1;
    cmd_if.cmd_op2    = op2;
  endtask

  task automatic load_flags(input logic [3:0] f);
    flag_wr_en = 1'b1; flag_wr_data = f;
    tick();
    flag_wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flag_wr_en = 1'b0; flag_wr_data = 4'h0;
    send(COND_AL, OP_AND, 1'b0, 4'd0, 32'd0, 32'd0);
    cmd_if.cmd_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_flags", {28'd0, flags_nzcv}, 32'd0);
    check("rst_done",  {30'd0, done, done_passed}, 32'd0);
    check("rst_alu",   {28'd0, alu_opcode} | alu_in_1 | alu_in_2, 32'd0);

    // ADDS overflow: 0x7FFFFFFF + 1 -> 0x80000000, NZCV = 1001
    send(COND_AL, OP_ADD, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'd1);
    tick();                                    // T+1 EXEC
    cmd_if.cmd_valid = 1'b0;
    check("add_exec_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    check("add_exec_op",    {28'd0, alu_opcode}, {28'd0, OP_ADD});
    check("add_exec_in1",   alu_in_1, 32'h7FFF_FFFF);
    check("add_exec_in2",   alu_in_2, 32'd1);
    check("add_exec_we",    {30'd0, rf_we, done}, 32'd0);
    tick();                                    // T+2 WB
    check("add_wb_we",     {31'd0, rf_we}, 32'd1);
    check("add_wb_waddr",  {28'd0, rf_waddr}, 32'd3);
    check("add_wb_wdata",  rf_wdata, 32'h8000_0000);
    check("add_wb_done",   {30'd0, done, done_passed}, 32'd3);
    tick();
    check("add_flags",     {28'd0, flags_nzcv}, 32'b1001);
    check("add_idle_done", {30'd0, rf_we, done}, 32'd0);

    // CMP 5,5: no write, NZCV = 0110
    send(COND_AL, OP_CMP, 1'b0, 4'd7, 32'd5, 32'd5);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("cmp_exec_op", {28'd0, alu_opcode}, {28'd0, OP_CMP});
    tick();
    check("cmp_wb_done", {30'd0, done, done_passed}, 32'd3);
    check("cmp_wb_we",   {31'd0, rf_we}, 32'd0);
    tick();
    check("cmp_flags",   {28'd0, flags_nzcv}, 32'b0110);

    // MOVNE with Z=1: fails, done at T+1, no write, flags unchanged
    load_flags(4'b0100);
    send(COND_NE, OP_MOV, 1'b1, 4'd1, 32'd0, 32'h55);
    tick();                                    // T+1 WB
    cmd_if.cmd_valid = 1'b0;
    check("ne_wb_done",  {30'd0, done, done_passed}, 32'd2);
    check("ne_wb_we",    {31'd0, rf_we}, 32'd0);
    check("ne_wb_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    check("ne_wb_alu",   {28'd0, alu_opcode} | alu_in_2, 32'd0);
    tick();
    check("ne_flags",    {28'd0, flags_nzcv}, 32'b0100);
    check("ne_idle",     {30'd0, done, cmd_if.cmd_ready}, 32'd1);

    // ORRS giving 0 with C=V=1: N/Z update, C/V retained -> 0111
    load_flags(4'b0011);
    send(COND_AL, OP_ORR, 1'b1, 4'd4, 32'd0, 32'd0);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("orr_exec_cin", {31'd0, alu_c_in}, 32'd1);
    tick();
    check("orr_wb_we",    {31'd0, rf_we}, 32'd1);
    check("orr_wb_waddr", {28'd0, rf_waddr}, 32'd4);
    check("orr_wb_wdata", rf_wdata, 32'd0);
    tick();
    check("orr_flags",    {28'd0, flags_nzcv}, 32'b0111);

    // Back-to-back with cmd_valid held: ADD rd5 = 30, then SUBEQS rd6 = 22
    send(COND_AL, OP_ADD, 1'b0, 4'd5, 32'd10, 32'd20);
    check("b2b_t0_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    tick();                                    // EXEC of first
    send(COND_EQ, OP_SUB, 1'b1, 4'd6, 32'd30, 32'd8);
    check("b2b_t1_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    tick();                                    // WB of first
    check("b2b_t2_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    check("b2b_t2_waddr", {27'd0, rf_we, rf_waddr}, 32'h15);
    check("b2b_t2_wdata", rf_wdata, 32'd30);
    tick();                                    // IDLE, second accepted here
    check("b2b_t3_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("b2b_t3_we",    {31'd0, rf_we}, 32'd0);
    tick();                                    // EXEC of second
    cmd_if.cmd_valid = 1'b0;
    check("b2b_t4_op",    {28'd0, alu_opcode}, {28'd0, OP_SUB});
    check("b2b_t4_in1",   alu_in_1, 32'd30);
    tick();                                    // WB of second
    check("b2b_t5_waddr", {27'd0, rf_we, rf_waddr}, 32'h16);
    check("b2b_t5_wdata", rf_wdata, 32'd22);
    tick();
    check("b2b_flags",    {28'd0, flags_nzcv}, 32'b0010);

    // Load coinciding with acceptance: EQ sees pre-load Z=0 -> fail
    send(COND_EQ, OP_ADD, 1'b1, 4'd9, 32'd1, 32'd1);
    flag_wr_en = 1'b1; flag_wr_data = 4'b0100;
    tick();
    flag_wr_en = 1'b0; cmd_if.cmd_valid = 1'b0;
    check("acc_ld_done", {30'd0, done, done_passed}, 32'd2);
    check("acc_ld_flag", {28'd0, flags_nzcv}, 32'b0100);
    tick();

    // Load coinciding with WB flag update: load wins
    send(COND_AL, OP_ADD, 1'b1, 4'd8, 32'd1, 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();                                    // WB
    check("wb_ld_wdata", rf_wdata, 32'd2);
    flag_wr_en = 1'b1; flag_wr_data = 4'b1001;
    tick();
    flag_wr_en = 1'b0;
    check("wb_ld_flags", {28'd0, flags_nzcv}, 32'b1001);

    // Reset during EXEC aborts: no write, no done, flags cleared
    send(COND_AL, OP_ADD, 1'b1, 4'd2, 32'd1, 32'd2);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("abort_exec_op", {28'd0, alu_opcode}, {28'd0, OP_ADD});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_we_done", {30'd0, rf_we, done}, 32'd0);
    check("abort_flags",   {28'd0, flags_nzcv}, 32'd0);
    check("abort_ready",   {31'd0, cmd_if.cmd_ready}, 32'd1);
    tick();
    check("abort_after",   {30'd0, rf_we, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
